id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Pipeline register between Decode and Execute in the RV32I 5-stage core.
- Captures decoded operands, register indices and control bits from ID each cycle.
- Decodes ALUOp/funct3/funct7[5] into the 4-bit ALU select consumed by the EX-stage N-bit adder / 16:1 result mux.
- Supports stall (hold) and flush (bubble insertion) for the hazard unit.

Parameters:
- N, 32, datapath width of PC, operands and immediate
- REG_ADDR_W, 5, register index width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold all EX outputs unchanged
- flush  input  1  load a bubble on next edge
- id_valid  input  1  ID holds a real instruction
- id_pc  input  N  instruction PC
- id_rs1_data  input  N  register-file read data 1
- id_rs2_data  input  N  register-file read data 2
- id_imm  input  N  sign-extended immediate
- id_rs1, id_rs2, id_rd  input  REG_ADDR_W each  register indices
- id_alu_op  input  2  00 mem, 01 branch, 10 R-type, 11 I-type ALU
- id_funct3  input  3  instruction funct3
- id_funct7_5  input  1  instruction bit 30
- id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  input  1 each  control bits
- ex_valid  output  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  N each  registered copies
- ex_rs1, ex_rs2, ex_rd  output  REG_ADDR_W each  registered indices
- ex_alu_sel  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 illegal
- ex_alu_illegal  output  1  unsupported ALU combination latched
- ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  output  1 each  registered controls

Behaviour:
- Reset: rst high forces every output to 0 asynchronously, including ex_valid and ex_alu_sel = 0000. Outputs stay 0 while rst is high. Release takes effect at the next clk edge.
- Priority per rising edge: rst > flush > stall > load.
- Flush: on the next edge, all outputs become 0 (bubble).
  - Flush overrides a simultaneous stall.
- Stall (flush low): all outputs hold their previous values, including ex_alu_illegal.
- Load: all ex_* outputs take the ID values on the next edge. Latency is 1 cycle.
- id_valid = 0 on load loads a bubble, identical to flush. Data fields are also zeroed so no stale indices reach the forwarding logic.
- ALU decode is combinational from ID inputs and is registered with the rest:
  - alu_op 00: ADD.
  - alu_op 01: SUB.
  - alu_op 10:
    - funct3 000 with funct7_5 = 0: ADD.
    - funct3 000 with funct7_5 = 1: SUB.
    - funct3 111: AND.
    - funct3 110: OR.
    - any other funct3: illegal.
  - alu_op 11:
    - funct3 000: ADD, funct7_5 ignored.
    - funct3 111: AND.
    - funct3 110: OR.
    - any other funct3: illegal.
- Illegal combination:
  - ex_alu_sel = 1111 and ex_alu_illegal = 1.
  - ex_reg_write, ex_mem_write and ex_mem_read are forced to 0 so the instruction has no architectural effect.
  - ex_valid stays 1 so the trap logic can see it.
- ex_alu_illegal is 0 for every bubble.
- No arithmetic in this block; all widths pass through unmodified.
- Reset asserted mid-stall clears the stage. After release, the stage loads normally on the first edge with stall low.

Test Plan:
- Reset: rst = 1 with random ID inputs, then hold 3 cycles -> all outputs 0, ex_alu_sel = 0000. Deassert rst with ID = add x3,x1,x2 -> next edge ex_valid = 1, ex_rd = 3, ex_alu_sel = 0010.
- Decode sweep: alu_op 10 with {funct3, f7_5} = {000,0}, {000,1}, {111,0}, {110,0}, {100,0} -> sel 0010, 0110, 0000, 0001, 1111 (last: illegal = 1, reg_write = 0). alu_op 11 with funct3 000 and f7_5 = 1 -> 0010. alu_op 01 -> 0110.
- Stall: load pc = 0x100, then stall for 4 cycles while ID changes to pc = 0x104 -> ex_pc stays 0x100. Release -> ex_pc = 0x104 one edge later.
- Flush vs stall: stall = 1 and flush = 1 on the same edge with a valid sw in EX -> next edge ex_valid = 0, ex_mem_write = 0, ex_rd = 0, ex_alu_sel = 0000.
- Bubble via id_valid: id_valid = 0 with id_reg_write = 1 and id_rd = 7 -> ex_reg_write = 0, ex_rd = 0, ex_valid = 0.
- Async reset mid-operation: assert rst between clock edges while stalled holding lw x5 -> outputs clear immediately, without waiting for clk.

Source files
------------

// File: rtl/id_ex_if.sv
// Bundle of the ID-side inputs and EX-side outputs of the ID/EX pipeline register.
// The hazard unit and decoder drive the master side; the stage register is the slave.
interface id_ex_if #(
    parameter int N          = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  stall;
    logic                  flush;
    logic                  id_valid;
    logic [N-1:0]          id_pc;
    logic [N-1:0]          id_rs1_data;
    logic [N-1:0]          id_rs2_data;
    logic [N-1:0]          id_imm;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [1:0]            id_alu_op;
    logic [2:0]            id_funct3;
    logic                  id_funct7_5;
    logic                  id_alu_src;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  id_mem_to_reg;
    logic                  id_branch;

    logic                  ex_valid;
    logic [N-1:0]          ex_pc;
    logic [N-1:0]          ex_rs1_data;
    logic [N-1:0]          ex_rs2_data;
    logic [N-1:0]          ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [3:0]            ex_alu_sel;
    logic                  ex_alu_illegal;
    logic                  ex_alu_src;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_mem_to_reg;
    logic                  ex_branch;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_op, id_funct3, id_funct7_5,
               id_alu_src, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_branch,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_alu_sel, ex_alu_illegal,
               ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_branch
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_op, id_funct3, id_funct7_5,
               id_alu_src, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_branch,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_alu_sel, ex_alu_illegal,
               ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_branch
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the RV32I core: captures operands and controls,
// decodes the ALU select, and supports stall (hold) and flush (bubble).
module id_ex_stage_reg #(
    parameter int N          = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic  clk,
    input  logic  rst,
    id_ex_if.slave bus
);
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_ILL = 4'b1111
    } alu_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [N-1:0]          pc;
        logic [N-1:0]          rs1_data;
        logic [N-1:0]          rs2_data;
        logic [N-1:0]          imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [3:0]            alu_sel;
        logic                  alu_illegal;
        logic                  alu_src;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  branch;
    } ex_bundle_t;

    alu_sel_e   alu_sel_dec;
    logic       alu_ill_dec;
    ex_bundle_t stage_reg;
    ex_bundle_t stage_next;

    always_comb begin
        alu_sel_dec = ALU_ADD;
        case (bus.id_alu_op)
            2'b00: alu_sel_dec = ALU_ADD;
            2'b01: alu_sel_dec = ALU_SUB;
            2'b10: begin
                case (bus.id_funct3)
                    3'b000:  alu_sel_dec = bus.id_funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_sel_dec = ALU_AND;
                    3'b110:  alu_sel_dec = ALU_OR;
                    default: alu_sel_dec = ALU_ILL;
                endcase
            end
            default: begin
                // I-type: bit 30 is part of the immediate, so it never selects SUB
                case (bus.id_funct3)
                    3'b000:  alu_sel_dec = ALU_ADD;
                    3'b111:  alu_sel_dec = ALU_AND;
                    3'b110:  alu_sel_dec = ALU_OR;
                    default: alu_sel_dec = ALU_ILL;
                endcase
            end
        endcase
        alu_ill_dec = (alu_sel_dec == ALU_ILL);
    end

    always_comb begin
        stage_next = stage_reg;
        if (bus.flush) begin
            stage_next = '0;
        end else if (!bus.stall) begin
            if (!bus.id_valid) begin
                stage_next = '0;
            end else begin
                stage_next.valid       = 1'b1;
                stage_next.pc          = bus.id_pc;
                stage_next.rs1_data    = bus.id_rs1_data;
                stage_next.rs2_data    = bus.id_rs2_data;
                stage_next.imm         = bus.id_imm;
                stage_next.rs1         = bus.id_rs1;
                stage_next.rs2         = bus.id_rs2;
                stage_next.rd          = bus.id_rd;
                stage_next.alu_sel     = alu_sel_dec;
                stage_next.alu_illegal = alu_ill_dec;
                stage_next.alu_src     = bus.id_alu_src;
                // Illegal ops stay valid for the trap logic but must not touch state
                stage_next.reg_write   = bus.id_reg_write & ~alu_ill_dec;
                stage_next.mem_read    = bus.id_mem_read  & ~alu_ill_dec;
                stage_next.mem_write   = bus.id_mem_write & ~alu_ill_dec;
                stage_next.mem_to_reg  = bus.id_mem_to_reg;
                stage_next.branch      = bus.id_branch;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign bus.ex_valid       = stage_reg.valid;
    assign bus.ex_pc          = stage_reg.pc;
    assign bus.ex_rs1_data    = stage_reg.rs1_data;
    assign bus.ex_rs2_data    = stage_reg.rs2_data;
    assign bus.ex_imm         = stage_reg.imm;
    assign bus.ex_rs1         = stage_reg.rs1;
    assign bus.ex_rs2         = stage_reg.rs2;
    assign bus.ex_rd          = stage_reg.rd;
    assign bus.ex_alu_sel     = stage_reg.alu_sel;
    assign bus.ex_alu_illegal = stage_reg.alu_illegal;
    assign bus.ex_alu_src     = stage_reg.alu_src;
    assign bus.ex_reg_write   = stage_reg.reg_write;
    assign bus.ex_mem_read    = stage_reg.mem_read;
    assign bus.ex_mem_write   = stage_reg.mem_write;
    assign bus.ex_mem_to_reg  = stage_reg.mem_to_reg;
    assign bus.ex_branch      = stage_reg.branch;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed plan steps followed by random traffic,
// each edge checked against a behavioural model of the stage.
module tb_id_ex_stage_reg;
    localparam int N  = 32;
    localparam int RW = 5;
    localparam int VW = 1 + 4*N + 3*RW + 4 + 7;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    id_ex_if #(.N(N), .REG_ADDR_W(RW)) bus ();

    id_ex_stage_reg #(.N(N), .REG_ADDR_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [N-1:0]  pc, rs1_data, rs2_data, imm;
        logic [RW-1:0] rs1, rs2, rd;
        logic [3:0]    sel;
        logic          ill, alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch;
    } model_t;

    model_t m;

    wire [VW-1:0] obs_vec = {bus.ex_valid, bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data,
                             bus.ex_imm, bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_alu_sel,
                             bus.ex_alu_illegal, bus.ex_alu_src, bus.ex_reg_write,
                             bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg,
                             bus.ex_branch};

    // Expected ALU select straight from the instruction-class rules
    function automatic logic [3:0] ref_sel(input logic [1:0] op, input logic [2:0] f3,
                                           input logic f7);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (f3 == 3'b111) return 4'b0000;
        if (f3 == 3'b110) return 4'b0001;
        if (f3 == 3'b000) return (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
        return 4'b1111;
    endfunction

    task automatic model_edge();
        model_t n;
        n = m;
        if (rst || bus.flush || (!bus.stall && !bus.id_valid)) begin
            n = '0;
        end else if (!bus.stall) begin
            n.valid      = 1'b1;
            n.pc         = bus.id_pc;
            n.rs1_data   = bus.id_rs1_data;
            n.rs2_data   = bus.id_rs2_data;
            n.imm        = bus.id_imm;
            n.rs1        = bus.id_rs1;
            n.rs2        = bus.id_rs2;
            n.rd         = bus.id_rd;
            n.sel        = ref_sel(bus.id_alu_op, bus.id_funct3, bus.id_funct7_5);
            n.ill        = (n.sel == 4'b1111);
            n.alu_src    = bus.id_alu_src;
            n.reg_write  = bus.id_reg_write && !n.ill;
            n.mem_read   = bus.id_mem_read && !n.ill;
            n.mem_write  = bus.id_mem_write && !n.ill;
            n.mem_to_reg = bus.id_mem_to_reg;
            n.branch     = bus.id_branch;
        end
        m = n;
    endtask

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model, then compare all outputs after the edge
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag, obs_vec, m);
    endtask

    task automatic rand_id();
        bus.id_valid      = ($urandom_range(0, 7) != 0);
        bus.id_pc         = $urandom;
        bus.id_rs1_data   = $urandom;
        bus.id_rs2_data   = $urandom;
        bus.id_imm        = $urandom;
        bus.id_rs1        = RW'($urandom);
        bus.id_rs2        = RW'($urandom);
        bus.id_rd         = RW'($urandom);
        bus.id_alu_op     = 2'($urandom);
        bus.id_funct3     = 3'($urandom);
        bus.id_funct7_5   = 1'($urandom);
        bus.id_alu_src    = 1'($urandom);
        bus.id_reg_write  = 1'($urandom);
        bus.id_mem_read   = 1'($urandom);
        bus.id_mem_write  = 1'($urandom);
        bus.id_mem_to_reg = 1'($urandom);
        bus.id_branch     = 1'($urandom);
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                             input logic [RW-1:0] rd, input logic src, input logic rw,
                             input logic mr, input logic mw, input logic m2r);
        rand_id();
        bus.id_valid      = 1'b1;
        bus.id_alu_op     = op;
        bus.id_funct3     = f3;
        bus.id_funct7_5   = f7;
        bus.id_rd         = rd;
        bus.id_alu_src    = src;
        bus.id_reg_write  = rw;
        bus.id_mem_read   = mr;
        bus.id_mem_write  = mw;
        bus.id_mem_to_reg = m2r;
        bus.id_branch     = 1'b0;
    endtask

    logic [1:0] sw_op [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
    logic [2:0] sw_f3 [7] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000};
    logic       sw_f7 [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] sw_sel[7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1111, 4'b0010, 4'b0110};

    initial begin
        m = '0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        rand_id();
        #1;
        check("reset_async", obs_vec, '0);
        for (int i = 0; i < 3; i++) begin
            step("reset_hold");
            check1("reset_sel", 32'(bus.ex_alu_sel), 32'h0);
            rand_id();
        end

        // add x3, x1, x2 as the first instruction after release
        rst = 1'b0;
        set_instr(2'b10, 3'b000, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.id_rs1 = 5'd1;
        bus.id_rs2 = 5'd2;
        step("first_add");
        check1("first_add_valid", 32'(bus.ex_valid), 32'h1);
        check1("first_add_rd", 32'(bus.ex_rd), 32'h3);
        check1("first_add_sel", 32'(bus.ex_alu_sel), 32'h2);

        for (int i = 0; i < 7; i++) begin
            set_instr(sw_op[i], sw_f3[i], sw_f7[i], 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            step("sweep");
            check1("sweep_sel", 32'(bus.ex_alu_sel), 32'(sw_sel[i]));
            check1("sweep_illegal", 32'(bus.ex_alu_illegal), 32'(sw_sel[i] == 4'hF));
            check1("sweep_reg_write", 32'(bus.ex_reg_write), 32'(sw_sel[i] != 4'hF));
            check1("sweep_valid", 32'(bus.ex_valid), 32'h1);
        end

        set_instr(2'b10, 3'b111, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.id_pc = 32'h100;
        step("stall_load");
        bus.stall = 1'b1;
        bus.id_pc = 32'h104;
        for (int i = 0; i < 4; i++) begin
            step("stall_hold");
            check1("stall_pc", bus.ex_pc, 32'h100);
        end
        bus.stall = 1'b0;
        step("stall_release");
        check1("release_pc", bus.ex_pc, 32'h104);

        // sw in EX, then simultaneous stall and flush
        set_instr(2'b00, 3'b010, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("sw_load");
        check1("sw_mem_write", 32'(bus.ex_mem_write), 32'h1);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step("flush_stall");
        check1("flush_valid", 32'(bus.ex_valid), 32'h0);
        check1("flush_mem_write", 32'(bus.ex_mem_write), 32'h0);
        check1("flush_rd", 32'(bus.ex_rd), 32'h0);
        check1("flush_sel", 32'(bus.ex_alu_sel), 32'h0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        set_instr(2'b10, 3'b000, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.id_valid = 1'b0;
        step("id_bubble");
        check1("bubble_reg_write", 32'(bus.ex_reg_write), 32'h0);
        check1("bubble_rd", 32'(bus.ex_rd), 32'h0);
        check1("bubble_valid", 32'(bus.ex_valid), 32'h0);

        // lw x5 held by stall, then reset asserted between edges
        set_instr(2'b00, 3'b010, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("lw_load");
        bus.stall = 1'b1;
        rand_id();
        step("lw_stall");
        check1("lw_rd_held", 32'(bus.ex_rd), 32'h5);
        #3;
        rst = 1'b1;
        #1;
        m = '0;
        check("async_reset", obs_vec, '0);
        step("reset_while_stalled");
        #3;
        rst = 1'b0;
        bus.stall = 1'b0;
        set_instr(2'b11, 3'b110, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("post_reset_load");
        check1("post_reset_sel", 32'(bus.ex_alu_sel), 32'h1);

        for (int i = 0; i < 300; i++) begin
            rand_id();
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
